// File: rtl/npu_pkg.sv
// npu_pkg: shared widths, SEL codes, SSFR bit positions and FSM states for the NPU MNIST datapath.
package npu_pkg;
    localparam int DW    = 8;
    localparam int AW    = 20;
    localparam int SHIFT = 7;

    localparam logic [2:0] SEL_FIFO = 3'b000;
    localparam logic [2:0] SEL_PISO = 3'b001;
    localparam logic [2:0] SEL_COMP = 3'b010;

    localparam int SSFR_SEL_LO    = 13;
    localparam int COMP_EN_BIT    = 10;
    localparam int FIFO_EN_BIT    = 9;
    localparam int FIFO_RST_N_BIT = 8;
    localparam int COMP_RST_N_BIT = 7;
    localparam logic [15:0] SSFR_RST = 16'h2000;

    typedef enum logic [2:0] {IDLE, CFG, LOAD_W, COMPUTE, OUT} state_t;

    // Floor-scale the accumulator and clamp to a signed byte.
    function automatic logic [DW-1:0] sat8(input logic signed [AW-1:0] a);
        logic signed [AW-1:0] s;
        s = a >>> SHIFT;
        return (s > 20'sd127) ? 8'h7F : (s < -20'sd128) ? 8'h80 : s[DW-1:0];
    endfunction
endpackage

// File: rtl/npu_out_fifo.sv
// npu_out_fifo: synchronous result FIFO; pushes on full and pops on empty are dropped.
module npu_out_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 8
) (
    input  logic         CLKEXT,
    input  logic         RST_GLO,
    input  logic         clr,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         FULL,
    output logic         EMPTY
);
    localparam int PW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wp, rp;
    logic [PW:0]   cnt;
    logic          do_push, do_pop;

    assign do_push = push && !FULL;
    assign do_pop  = pop && !EMPTY;
    assign FULL    = cnt == (PW+1)'(DEPTH);
    assign EMPTY   = cnt == '0;

    always_ff @(posedge CLKEXT)
        if (do_push) mem[wp] <= din;

    always_ff @(posedge CLKEXT or negedge RST_GLO)
        if (!RST_GLO) begin
            wp   <= '0;
            rp   <= '0;
            cnt  <= '0;
            dout <= '0;
        end else if (clr) begin
            wp   <= '0;
            rp   <= '0;
            cnt  <= '0;
            dout <= '0;
        end else begin
            if (do_push) wp <= wp + PW'(1);
            if (do_pop) begin
                dout <= mem[rp];
                rp   <= rp + PW'(1);
            end
            cnt <= cnt + (PW+1)'(do_push) - (PW+1)'(do_pop);
        end
endmodule

// File: rtl/npu_mnist_top.sv
// npu_mnist_top: SSFR, run FSM, 4-lane MAC and PISO/FIFO/argmax/debug output paths.
// Define NPU_AUTO_COMP_EN to build in the argmax comparator.
module npu_mnist_top
    import npu_pkg::*;
#(
    parameter int N_VEC      = 8,
    parameter int FIFO_DEPTH = 8
) (
    input  logic          CLKEXT,
    input  logic          RST_GLO,
    input  logic          EN_FSM,
    input  logic          EN_CONFIG,
    input  logic [DW-1:0] DA,
    input  logic [DW-1:0] DB,
    input  logic [DW-1:0] DC,
    input  logic [DW-1:0] DD,
    input  logic          RD_EN,
    input  logic          EN_PISO_DEB,
    input  logic          CLR_PISO_DEB,
    input  logic          SHIFT_DEB,
    input  logic          SEL_CON,
    output logic [DW-1:0] D_OUT,
    output logic          FULL,
    output logic          EMPTY
);
    localparam int CW = (N_VEC > 4) ? $clog2(N_VEC) : 2;

    state_t               state;
    logic [CW-1:0]        cnt;
    logic [2:0]           sel;
    logic                 fifo_en, fifo_rst_n, out_st;
    logic [DW-1:0]        din [4];
    logic signed [DW-1:0] w [4];
    logic signed [AW-1:0] acc [4];
    logic [DW-1:0]        r [4];
    logic [DW-1:0]        piso_q, fifo_q, comp_q, lane_r;
    logic [4*DW-1:0]      deb;

    assign din    = '{DA, DB, DC, DD};
    assign out_st = state == OUT;
    assign lane_r = r[cnt[1:0]];

    always_comb
        for (int i = 0; i < 4; i++) r[i] = sat8(acc[i]);

    always_ff @(posedge CLKEXT or negedge RST_GLO)
        if (!RST_GLO) begin
            state      <= IDLE;
            cnt        <= '0;
            sel        <= SSFR_RST[SSFR_SEL_LO +: 3];
            fifo_en    <= SSFR_RST[FIFO_EN_BIT];
            fifo_rst_n <= SSFR_RST[FIFO_RST_N_BIT];
            for (int i = 0; i < 4; i++) begin
                w[i]   <= '0;
                acc[i] <= '0;
            end
        end else begin
            case (state)
                IDLE:
                    if (EN_FSM) begin
                        state <= EN_CONFIG ? CFG : LOAD_W;
                        if (EN_CONFIG) begin
                            sel        <= DA[SSFR_SEL_LO-8 +: 3];
                            fifo_en    <= DA[FIFO_EN_BIT-8];
                            fifo_rst_n <= DA[FIFO_RST_N_BIT-8];
                        end
                    end
                CFG: state <= LOAD_W;
                LOAD_W: begin
                    for (int i = 0; i < 4; i++) begin
                        w[i]   <= din[i];
                        acc[i] <= '0;
                    end
                    cnt   <= '0;
                    state <= COMPUTE;
                end
                COMPUTE: begin
                    for (int i = 0; i < 4; i++)
                        acc[i] <= acc[i] + AW'(w[i]) * AW'($signed(din[i]));
                    cnt <= cnt + CW'(1);
                    if (cnt == CW'(N_VEC-1)) begin
                        cnt   <= '0;
                        state <= OUT;
                    end
                end
                OUT: begin
                    cnt <= cnt + CW'(1);
                    if (cnt == CW'(3)) begin
                        cnt   <= '0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end

    npu_out_fifo #(.DEPTH(FIFO_DEPTH), .W(DW)) u_fifo (
        .CLKEXT (CLKEXT),
        .RST_GLO(RST_GLO),
        .clr    (!fifo_rst_n),
        .push   (out_st && fifo_en),
        .pop    (RD_EN),
        .din    (lane_r),
        .dout   (fifo_q),
        .FULL   (FULL),
        .EMPTY  (EMPTY)
    );

`ifdef NPU_AUTO_COMP_EN
    logic       comp_en, comp_rst_n, cfg_wr;
    logic [1:0] amax;

    assign cfg_wr = state == IDLE && EN_FSM && EN_CONFIG;

    // Strict greater-than keeps the lowest index on ties.
    always_comb begin
        int b;
        b = 0;
        for (int i = 1; i < 4; i++)
            if ($signed(r[i]) > $signed(r[b])) b = i;
        amax = 2'(b);
    end

    always_ff @(posedge CLKEXT or negedge RST_GLO)
        if (!RST_GLO) begin
            comp_en    <= SSFR_RST[COMP_EN_BIT];
            comp_rst_n <= SSFR_RST[COMP_RST_N_BIT];
            comp_q     <= '0;
        end else begin
            if (cfg_wr) begin
                comp_en    <= DA[COMP_EN_BIT-8];
                comp_rst_n <= DB[COMP_RST_N_BIT];
            end
            if (!comp_rst_n) comp_q <= '0;
            else if (comp_en && out_st && cnt == '0) comp_q <= {6'b0, amax};
        end
`else
    assign comp_q = '0;
`endif

    always_ff @(posedge CLKEXT or negedge RST_GLO)
        if (!RST_GLO) begin
            piso_q <= '0;
            deb    <= '0;
        end else begin
            piso_q <= out_st ? lane_r : '0;
            deb    <= CLR_PISO_DEB ? '0 :
                      EN_PISO_DEB  ? {r[0], r[1], r[2], r[3]} :
                      SHIFT_DEB    ? {deb[3*DW-1:0], DW'(0)} : deb;
        end

    always_comb
        D_OUT = !SEL_CON         ? deb[4*DW-1 -: DW] :
                sel == SEL_FIFO  ? fifo_q :
                sel == SEL_PISO  ? piso_q :
                sel == SEL_COMP  ? comp_q : '0;
endmodule

// File: tb/tb_npu_mnist_top.sv
// tb_npu_mnist_top: directed runs against a queue/integer model of the NPU output paths.
module tb_npu_mnist_top;
    localparam logic [31:0] WSTD = 32'hD800D808;
    localparam logic [63:0] XSTD = 64'hD7D6D5D4D3D2D1D0;
    localparam logic [63:0] XSAT = 64'h8080808080808080;

    logic       clk, RST_GLO, EN_FSM, EN_CONFIG, RD_EN;
    logic       EN_PISO_DEB, CLR_PISO_DEB, SHIFT_DEB, SEL_CON;
    logic [7:0] DA, DB, DC, DD, D_OUT;
    logic       FULL, EMPTY;

    npu_mnist_top dut (
        .CLKEXT(clk), .RST_GLO(RST_GLO), .EN_FSM(EN_FSM), .EN_CONFIG(EN_CONFIG),
        .DA(DA), .DB(DB), .DC(DC), .DD(DD), .RD_EN(RD_EN),
        .EN_PISO_DEB(EN_PISO_DEB), .CLR_PISO_DEB(CLR_PISO_DEB), .SHIFT_DEB(SHIFT_DEB),
        .SEL_CON(SEL_CON), .D_OUT(D_OUT), .FULL(FULL), .EMPTY(EMPTY)
    );

    always #5 clk = ~clk;

    int         n_checks = 0, n_err = 0;
    bit         chk_en = 0;
    logic [7:0] q[$];
    logic [7:0] fdout, mp, mc, exp_dout;
    logic [31:0] deb_m, m_r;
    logic [15:0] m_ssfr;
    logic       exp_full, exp_empty;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Expected lane bytes straight from the arithmetic definition.
    function automatic logic [31:0] results(input logic [31:0] w, input logic [63:0] x);
        logic [31:0] res;
        int acc, s;
        for (int i = 0; i < 4; i++) begin
            acc = 0;
            for (int v = 0; v < 8; v++)
                acc += int'($signed(w[31-8*i -: 8])) * int'($signed(x[8*v +: 8]));
            s = acc >>> 7;
            if (s > 127) s = 127;
            if (s < -128) s = -128;
            res[31-8*i -: 8] = 8'(s);
        end
        return res;
    endfunction

    function automatic logic [7:0] argmax(input logic [31:0] rr);
        int b = 0;
        for (int i = 1; i < 4; i++)
            if ($signed(rr[31-8*i -: 8]) > $signed(rr[31-8*b -: 8])) b = i;
        return 8'(b);
    endfunction

    function void model_reset();
        q.delete();
        fdout = 0; mp = 0; mc = 0; deb_m = 0; m_r = 0; m_ssfr = 16'h2000;
    endfunction

    // Effect of one clock edge; oi is the result index emitted this edge, -1 if none.
    function automatic void model_edge(input int oi);
        int sz;
        if (!RST_GLO) begin
            model_reset();
            return;
        end
        sz = q.size();
        if (!m_ssfr[8]) begin
            q.delete();
            fdout = 0;
        end else begin
            if (RD_EN && sz > 0) fdout = q.pop_front();
            if (m_ssfr[9] && oi >= 0 && sz < 8) q.push_back(m_r[31-8*oi -: 8]);
        end
`ifdef NPU_AUTO_COMP_EN
        if (!m_ssfr[7]) mc = 0;
        else if (m_ssfr[10] && oi == 0) mc = argmax(m_r);
`endif
        mp = (oi >= 0) ? m_r[31-8*oi -: 8] : 8'h00;
        if (CLR_PISO_DEB) deb_m = 0;
        else if (EN_PISO_DEB) deb_m = m_r;
        else if (SHIFT_DEB) deb_m = deb_m << 8;
    endfunction

    function void upd_exp();
        exp_dout = !SEL_CON ? deb_m[31:24] :
                   m_ssfr[15:13] == 3'b000 ? fdout :
                   m_ssfr[15:13] == 3'b001 ? mp :
                   m_ssfr[15:13] == 3'b010 ? mc : 8'h00;
        exp_full  = q.size() == 8;
        exp_empty = q.size() == 0;
    endfunction

    always @(negedge clk)
        if (chk_en) begin
            upd_exp();
            check("dout", D_OUT, exp_dout);
            check("full", FULL, exp_full);
            check("empty", EMPTY, exp_empty);
        end

    task automatic step(input int oi);
        @(posedge clk);
        #1;
        model_edge(oi);
    endtask

    task automatic run(input logic [31:0] w, input logic [63:0] x, input bit cfg,
                       input logic [15:0] cv, input logic [7:0] rdm, input int ign,
                       output logic [39:0] cap);
        EN_FSM = 1; EN_CONFIG = cfg; {DA, DB} = cv;
        step(-1);
        if (cfg) m_ssfr = cv;
        EN_FSM = 0; EN_CONFIG = 0;
        if (cfg) step(-1);
        {DA, DB, DC, DD} = w;
        step(-1);
        for (int v = 0; v < 8; v++) begin
            {DA, DB, DC, DD} = {4{x[8*v +: 8]}};
            RD_EN = rdm[v];
            EN_FSM = (v == ign); EN_CONFIG = (v == ign);
            step(-1);
        end
        EN_FSM = 0; EN_CONFIG = 0; RD_EN = 0; {DA, DB, DC, DD} = 0;
        m_r = results(w, x);
        for (int k = 0; k < 4; k++) begin
            step(k);
            cap[39-8*k -: 8] = D_OUT;
        end
        step(-1);
        cap[7:0] = D_OUT;
    endtask

    task automatic rd(output logic [7:0] b);
        RD_EN = 1;
        step(-1);
        b = D_OUT;
        RD_EN = 0;
        step(-1);
    endtask

    initial begin
        logic [39:0] cap;
        logic [31:0] dc;
        logic [63:0] rc;
        logic [7:0]  b;
        clk = 0; RST_GLO = 1; EN_FSM = 0; EN_CONFIG = 0; RD_EN = 0;
        EN_PISO_DEB = 0; CLR_PISO_DEB = 0; SHIFT_DEB = 0; SEL_CON = 1;
        {DA, DB, DC, DD} = 0;
        model_reset();
        #2 RST_GLO = 0;
        @(negedge clk);
        check("rst_dout", D_OUT, 8'h00);
        check("rst_empty", EMPTY, 1'b1);
        check("rst_full", FULL, 1'b0);
        chk_en = 1;
        step(-1);
        RST_GLO = 1;
        step(-1);

        check("model_std", results(WSTD, XSTD), 32'h6F006FE9);
        check("model_sat", results(32'h80808080, XSAT), 32'h7F7F7F7F);
        run(WSTD, XSTD, 0, 16'h0, 8'h0, -1, cap);
        check("piso_seq", cap, 40'h6F006FE900);

        EN_PISO_DEB = 1;
        step(-1);
        EN_PISO_DEB = 0; SEL_CON = 0;
        #1 check("deb_load", D_OUT, 8'h6F);
        SHIFT_DEB = 1;
        for (int k = 0; k < 4; k++) begin
            step(-1);
            dc[31-8*k -: 8] = D_OUT;
        end
        SHIFT_DEB = 0;
        check("deb_shift", dc, 32'h006FE900);
        EN_PISO_DEB = 1; CLR_PISO_DEB = 1;
        step(-1);
        EN_PISO_DEB = 0; CLR_PISO_DEB = 0;
        check("deb_clr", D_OUT, 8'h00);
        SEL_CON = 1;

        run(WSTD, XSTD, 1, 16'h0300, 8'b0001_1110, -1, cap);
        check("fifo_nonempty", EMPTY, 1'b0);
        check("fifo_notfull", FULL, 1'b0);
        for (int k = 0; k < 4; k++) begin
            rd(b);
            dc[31-8*k -: 8] = b;
        end
        check("fifo_rd4", dc, 32'h6F006FE9);
        check("fifo_drained", EMPTY, 1'b1);

        run(WSTD, XSTD, 0, 16'h0, 8'h0, -1, cap);
        run(WSTD, XSTD, 0, 16'h0, 8'h0, -1, cap);
        check("fifo_full", FULL, 1'b1);
        run(32'h000000D8, XSTD, 0, 16'h0, 8'h0, -1, cap);
        for (int k = 0; k < 8; k++) begin
            rd(b);
            rc[63-8*k -: 8] = b;
        end
        check("fifo_rd8", rc, 64'h6F006FE96F006FE9);
        rd(b);
        check("fifo_rd_empty", b, 8'hE9);
        check("fifo_empty_end", EMPTY, 1'b1);

        run(WSTD, XSTD, 1, 16'h4480, 8'h0, -1, cap);
        check("comp_tie", cap[7:0], 8'h00);
        run(32'h000000D8, XSTD, 0, 16'h0, 8'h0, -1, cap);
`ifdef NPU_AUTO_COMP_EN
        check("comp_lane3", cap[7:0], 8'h03);
`else
        check("comp_absent", cap[7:0], 8'h00);
`endif

        run(32'h80808080, XSAT, 1, 16'h2000, 8'h0, 3, cap);
        check("sat_pos", cap, 40'h7F7F7F7F00);
        run(32'h807F807F, XSAT, 0, 16'h0, 8'h0, -1, cap);
        check("sat_mix", cap, 40'h7F807F8000);

        EN_FSM = 1; EN_CONFIG = 1; {DA, DB} = 16'h0300;
        step(-1);
        m_ssfr = 16'h0300;
        EN_FSM = 0; EN_CONFIG = 0;
        step(-1);
        {DA, DB, DC, DD} = WSTD;
        step(-1);
        for (int v = 0; v < 3; v++) begin
            {DA, DB, DC, DD} = {4{XSTD[8*v +: 8]}};
            step(-1);
        end
        RST_GLO = 0;
        model_reset();
        {DA, DB, DC, DD} = 0;
        step(-1);
        step(-1);
        RST_GLO = 1;
        repeat (12) step(-1);
        check("abort_dout", D_OUT, 8'h00);
        check("abort_empty", EMPTY, 1'b1);
        run(WSTD, XSTD, 0, 16'h0, 8'h0, -1, cap);
        check("post_abort_piso", cap, 40'h6F006FE900);

        chk_en = 0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule

// File: doc/npu_mnist_top.md
# npu_mnist_top

Top level of the NPU MNIST classifier datapath. It holds a 16-bit special-function configuration register (SSFR) and a run FSM. Each run loads four signed 8-bit weights, then accumulates eight 4-lane activation vectors. The four lane results go to one of three output paths: PISO byte stream, 8-deep FIFO, or argmax comparator (AUTO_COMP). A manual debug PISO path is also available.

## Interface
- `N_VEC`, 8: activation vectors accumulated per run.
- `FIFO_DEPTH`, 8: output FIFO depth (power of 2).
- `CLKEXT  in  1`: single clock, rising edge.
- `RST_GLO  in  1`: asynchronous, active-low reset.
- `EN_FSM  in  1`: start pulse for a run.
- `EN_CONFIG  in  1`: load SSFR; effective only together with EN_FSM.
- `DA, DB, DC, DD  in  8 each`: lane 0..3 weights or activations; DA/DB double as SSFR hi/lo during config.
- `RD_EN  in  1`: FIFO read strobe.
- `EN_PISO_DEB, CLR_PISO_DEB, SHIFT_DEB  in  1 each`: debug PISO load, clear and shift.
- `SEL_CON  in  1`: 1 = SSFR-selected output path; 0 = debug PISO.
- `D_OUT  out  8`: output byte.
- `FULL, EMPTY  out  1 each`: FIFO flags.

## Operation
- **SSFR fields:**
  - `SEL = SSFR[15:13]`: 000 FIFO, 001 PISO, 010 AUTO_COMP, others drive D_OUT = 0.
  - `SSFR[10]` COMP_EN; `SSFR[9]` FIFO_EN; `SSFR[8]` FIFO_RST_N (0 holds the FIFO cleared); `SSFR[7]` COMP_RST_N (0 clears the comparator).
  - Reset value 0x2000 (PISO mode, FIFO held in reset, comparator disabled).
- **FSM states:** IDLE, CFG, LOAD_W, COMPUTE, OUT.
  - IDLE → CFG on EN_FSM&EN_CONFIG; SSFR <= {DA,DB} on that same edge.
  - IDLE → LOAD_W on EN_FSM alone.
  - CFG → LOAD_W unconditionally.
  - LOAD_W: w_i <= lane input, clear accumulators, → COMPUTE.
  - COMPUTE: acc_i += w_i*x_i (signed 8x8, 20-bit accumulator) for N_VEC cycles, then → OUT.
  - OUT: 4 cycles, then → IDLE.
  - EN_FSM outside IDLE is ignored.
- **Lane result:** `r_i = sat8(acc_i >>> 7)`, arithmetic shift (floor), saturated to −128..127.
- **PISO mode:** during OUT, D_OUT = r0, r1, r2, r3 on successive cycles; D_OUT = 0 afterwards.
- **FIFO mode:** when FIFO_EN=1, r0..r3 are pushed one per OUT cycle.
  - RD_EN & !EMPTY pops: D_OUT <= head.
  - Push when FULL is dropped; RD_EN when EMPTY is ignored.
  - Simultaneous push and pop are both honoured (at empty: only the push).
- **AUTO_COMP mode:** if COMP_EN, on the first OUT cycle D_OUT <= {6'b0, argmax_i r_i}; ties resolve to the lowest index. The value holds until the next result or comparator clear.
- **Debug path (SEL_CON=0):**
  - D_OUT = debug PISO MSB byte.
  - CLR_PISO_DEB clears the register (highest priority); EN_PISO_DEB loads {r0,r1,r2,r3}; SHIFT_DEB shifts one byte toward D_OUT.

## Timing
- **Reset values:** D_OUT=0, FULL=0, EMPTY=1, state IDLE, weights and accumulators 0, SSFR=0x2000.
- **Start sequence:** EN_FSM sampled at edge E.
  - Without config, weights are sampled at E+1.
  - With config, weights are sampled at E+2.
  - Activations follow at the next N_VEC edges, one per edge.
- **Output latency:** first result byte on D_OUT one edge after the last activation edge.
- **Mid-run behaviour:** reset aborts any run and clears everything. SSFR writes are accepted only in IDLE.

## Configuration
- `NPU_AUTO_COMP_EN` defined: comparator present.
- Undefined: comparator absent; SEL=010 drives D_OUT=0; COMP_EN and COMP_RST_N are ignored.

## Structure
- Package `npu_pkg` holds:
  - SEL codes.
  - FSM state enum.
  - SSFR bit positions and reset value.
  - Data, accumulator and shift widths.
- One natural sub-module: `npu_out_fifo` (sync FIFO with FULL/EMPTY flags).

## Test plan
All runs below use weights D8,00,D8,08 followed by eight activation quads D0..D7 (all four lanes equal per quad).
- **Reset:** RST_GLO=0 → D_OUT=00, EMPTY=1, FULL=0.
- **PISO (default):** reset, EN_FSM pulse, standard run → D_OUT = 6F, 00, 6F, E9, then 00.
- **FIFO:** config {03,00} with RD_EN held during vectors 2–5, standard run → reads on empty ignored. After the run EMPTY=0, FULL=0, and four RD_EN pulses return 6F, 00, 6F, E9, then EMPTY=1.
- **AUTO_COMP:** config {44,80}, standard run → D_OUT=00 (tie on 6F resolves to lane 0). Rerun with weights 00,00,00,D8 → D_OUT=03.
- **Saturation:** weights 80 on all lanes, eight 80 quads → r_i=7F in every lane.
- **Reset during COMPUTE:** → IDLE, no output, SSFR back to 0x2000.
